// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the pong game sequencer and the sync/graphic datapath.
// The master side is the datapath/sync generator; the slave side is the sequencer.
interface pong_game_ctrl_if;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic [1:0] btn;
  logic       hit;
  logic       miss;
  logic       gra_still;
  logic       ball_load;
  logic [7:0] score_bcd;
  logic [1:0] balls_left;
  logic       game_over;
  logic [1:0] state;

  modport master (
    output pixel_x, pixel_y, btn, hit, miss,
    input  gra_still, ball_load, score_bcd, balls_left, game_over, state
  );

  modport slave (
    input  pixel_x, pixel_y, btn, hit, miss,
    output gra_still, ball_load, score_bcd, balls_left, game_over, state
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game-level sequencer: round/ball FSM, BCD score, ball count and
// frame-based pause timer for the new-ball and game-over pauses.
module pong_game_ctrl #(
  parameter int unsigned BALLS        = 3,
  parameter int unsigned TIMER_FRAMES = 120
) (
  input logic             clk,
  input logic             rst,
  pong_game_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    NEWGAME = 2'b00,
    PLAY    = 2'b01,
    NEWBALL = 2'b10,
    OVER    = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] timer_cnt;
  logic       timer_start;
  logic       timer_up;
  logic       refr_tick;
  logic       btn_any;
  logic [3:0] units_q, units_d;
  logic [3:0] tens_q, tens_d;
  logic [1:0] balls_q, balls_d;
  logic       load_q, load_d;

  assign refr_tick = (bus.pixel_y == 10'd481) && (bus.pixel_x == 10'd0);
  assign timer_up  = (timer_cnt == '0);
  assign btn_any   = |bus.btn;

  // State register, datapath registers and pause timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= NEWGAME;
      timer_cnt <= '0;
      units_q   <= '0;
      tens_q    <= '0;
      balls_q   <= 2'(BALLS);
      load_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      units_q <= units_d;
      tens_q  <= tens_d;
      balls_q <= balls_d;
      load_q  <= load_d;
      if (timer_start)
        timer_cnt <= 8'(TIMER_FRAMES - 1);
      else if (refr_tick && !timer_up)
        timer_cnt <= timer_cnt - 8'd1;
    end
  end

  // Next-state, score and ball-count logic.
  always_comb begin
    state_d     = state_q;
    timer_start = 1'b0;
    load_d      = 1'b0;
    units_d     = units_q;
    tens_d      = tens_q;
    balls_d     = balls_q;
    unique case (state_q)
      NEWGAME: begin
        units_d = '0;
        tens_d  = '0;
        balls_d = 2'(BALLS);
        if (btn_any) begin
          state_d = PLAY;
          balls_d = 2'(BALLS - 1);
          load_d  = 1'b1;
        end
      end
      PLAY: begin
        if (bus.hit) begin
          if (units_q == 4'd9) begin
            units_d = '0;
            tens_d  = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
          end else begin
            units_d = units_q + 4'd1;
          end
        end
        if (bus.miss) begin
          timer_start = 1'b1;
          if (balls_q == '0) begin
            state_d = OVER;
          end else begin
            state_d = NEWBALL;
            balls_d = balls_q - 2'd1;
          end
        end
      end
      NEWBALL: begin
        if (timer_up && btn_any) begin
          state_d = PLAY;
          load_d  = 1'b1;
        end
      end
      OVER: begin
        // Clearing on the way out makes NEWGAME show a fresh game from its first cycle.
        if (timer_up) begin
          state_d = NEWGAME;
          units_d = '0;
          tens_d  = '0;
          balls_d = 2'(BALLS);
        end
      end
      default: state_d = NEWGAME;
    endcase
  end

  // Moore outputs.
  always_comb begin
    bus.gra_still  = (state_q != PLAY);
    bus.game_over  = (state_q == OVER);
    bus.ball_load  = load_q;
    bus.score_bcd  = {tens_q, units_q};
    bus.balls_left = balls_q;
    bus.state      = state_q;
  end

endmodule
